// File: rtl/inst_decode_stage.sv
// Registered decode stage for the 17-opcode ISA (NOP..JML) with a valid/ready handshake on both sides.
// Optional load-use interlock is enabled by defining DEC_HAZARD_EN.
module inst_decode_stage #(
    parameter  int OPC_W  = 5,
    parameter  int RA_W   = 3,
    parameter  int SH_W   = 3,
    parameter  int CNT_W  = 16,
    localparam int INST_W = OPC_W + 3*RA_W + SH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RA_W-1:0]   DA,
    output logic [RA_W-1:0]   AA,
    output logic [RA_W-1:0]   BA,
    output logic [SH_W-1:0]   SH,
    output logic [3:0]        FS,
    output logic [1:0]        BS,
    output logic [1:0]        MD,
    output logic              PS,
    output logic              MW,
    output logic              RW,
    output logic              MA,
    output logic              MB,
    output logic              CS,
    output logic              OE,
    output logic              ill_op,
    output logic              ill_seen,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  issue_cnt
);

    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SLT  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SBI  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_LSL  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_XRI  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_ADI  = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_BZ   = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_BNZ  = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_MOVA = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(15);
    localparam logic [OPC_W-1:0] OP_JML  = OPC_W'(16);

    logic [OPC_W-1:0] w_opc;
    logic [RA_W-1:0]  w_f_da, w_f_aa, w_f_ba, w_da, w_aa, w_ba;
    logic [SH_W-1:0]  w_sh;
    logic [3:0]       w_fs;
    logic [1:0]       w_bs, w_md;
    logic             w_ps, w_mw, w_rw, w_ma, w_mb, w_cs, w_oe, w_ill;
    logic             w_uses_a, w_uses_b, w_is_ld;
    logic             w_load_en, w_hazard, w_take;

    assign w_opc  = inst_in[INST_W-1 -: OPC_W];
    assign w_f_da = inst_in[INST_W-OPC_W-1 -: RA_W];
    assign w_f_aa = inst_in[INST_W-OPC_W-RA_W-1 -: RA_W];
    assign w_f_ba = inst_in[INST_W-OPC_W-2*RA_W-1 -: RA_W];

    // Instruction decoder: opcode to datapath controls and register-use flags
    always_comb begin
        w_da     = w_f_da;
        w_aa     = w_f_aa;
        w_ba     = '0;
        w_sh     = '0;
        w_fs     = 4'd0;
        w_bs     = 2'd0;
        w_md     = 2'd0;
        w_ps     = 1'b0;
        w_mw     = 1'b0;
        w_rw     = 1'b0;
        w_ma     = 1'b0;
        w_mb     = 1'b0;
        w_cs     = 1'b0;
        w_oe     = 1'b0;
        w_ill    = 1'b0;
        w_uses_a = 1'b1;
        w_uses_b = 1'b0;
        w_is_ld  = 1'b0;
        case (w_opc)
            OP_NOP:  begin w_da = '0; w_aa = '0; w_uses_a = 1'b0; end
            OP_ADD:  begin w_rw = 1'b1; w_fs = 4'd1; w_ba = w_f_ba; w_uses_b = 1'b1; end
            OP_OUT:  begin w_fs = 4'd2; w_oe = 1'b1; w_ba = w_f_ba; w_uses_b = 1'b1; end
            OP_SLT:  begin w_rw = 1'b1; w_fs = 4'd3; w_ba = w_f_ba; w_md = 2'd2; w_uses_b = 1'b1; end
            OP_AND:  begin w_rw = 1'b1; w_fs = 4'd4; w_ba = w_f_ba; w_uses_b = 1'b1; end
            OP_LD:   begin w_rw = 1'b1; w_fs = 4'd5; w_md = 2'd1; w_is_ld = 1'b1; end
            OP_SBI:  begin w_rw = 1'b1; w_fs = 4'd6; w_ba = w_f_ba; w_uses_b = 1'b1; end
            OP_LSL:  begin w_rw = 1'b1; w_fs = 4'd7; w_ba = w_f_ba; w_sh = inst_in[SH_W-1:0]; w_uses_b = 1'b1; end
            OP_IN:   begin w_rw = 1'b1; w_fs = 4'd8; w_uses_a = 1'b0; end
            OP_XRI:  begin w_rw = 1'b1; w_fs = 4'd9; w_ba = w_f_ba; w_mb = 1'b1; w_uses_b = 1'b1; end
            OP_ADI:  begin w_rw = 1'b1; w_fs = 4'd10; w_mb = 1'b1; end
            OP_BZ:   begin w_fs = 4'd11; w_bs = 2'b01; w_mb = 1'b1; w_cs = 1'b1; w_da = '0; end
            OP_BNZ:  begin w_fs = 4'd12; w_bs = 2'b01; w_ps = 1'b1; w_mb = 1'b1; w_cs = 1'b1; w_da = '0; end
            OP_ST:   begin w_mw = 1'b1; w_ba = w_f_ba; w_uses_b = 1'b1; end
            OP_MOVA: begin w_rw = 1'b1; w_fs = 4'd13; end
            OP_JMP:  begin w_bs = 2'b11; w_mb = 1'b1; w_cs = 1'b1; w_da = '0; w_aa = '0; w_uses_a = 1'b0; end
            OP_JML:  begin w_bs = 2'b10; w_rw = 1'b1; w_mb = 1'b1; w_cs = 1'b1; end
            default: begin w_da = '0; w_aa = '0; w_ill = 1'b1; w_uses_a = 1'b0; end
        endcase
    end

    assign w_load_en = !out_valid | out_ready;
    assign in_ready  = w_load_en & !w_hazard & !flush;
    assign w_take    = w_load_en & in_valid & !w_hazard & !flush;

`ifdef DEC_HAZARD_EN
    typedef enum logic {RUN = 1'b0, LDP = 1'b1} hz_state_t;
    hz_state_t        r_state;
    logic [RA_W-1:0]  r_ld_da;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_hazard = (r_state == LDP) & in_valid &
                      ((w_uses_a & (w_f_aa == r_ld_da)) | (w_uses_b & (w_f_ba == r_ld_da)));
    assign stall_cnt = r_stall_cnt;

    // Load-use tracker: LDP while an LD sits in the output register; a hit inserts one bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_ld_da     <= '0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_state <= RUN;
        end else if (w_load_en & w_hazard) begin
            r_state <= RUN;
            if (r_stall_cnt != {CNT_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end else if (w_take) begin
            r_state <= w_is_ld ? LDP : RUN;
            r_ld_da <= w_da;
        end
    end
`else
    logic w_unused_hz;
    assign w_unused_hz = &{1'b0, w_uses_a, w_uses_b, w_is_ld};
    assign w_hazard    = 1'b0;
    assign stall_cnt   = '0;
`endif

    logic [RA_W-1:0]  r_da, r_aa, r_ba;
    logic [SH_W-1:0]  r_sh;
    logic [3:0]       r_fs;
    logic [1:0]       r_bs, r_md;
    logic             r_ps, r_mw, r_rw, r_ma, r_mb, r_cs, r_oe, r_ill, r_ill_seen, r_out_valid;
    logic [CNT_W-1:0] r_issue_cnt;

    // Output pipeline register; a flushed or bubbled slot keeps stale controls with out_valid low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_da <= '0; r_aa <= '0; r_ba <= '0; r_sh <= '0;
            r_fs <= 4'd0; r_bs <= 2'd0; r_md <= 2'd0;
            r_ps <= 1'b0; r_mw <= 1'b0; r_rw <= 1'b0; r_ma <= 1'b0;
            r_mb <= 1'b0; r_cs <= 1'b0; r_oe <= 1'b0; r_ill <= 1'b0;
            r_ill_seen  <= 1'b0;
            r_issue_cnt <= '0;
        end else begin
            if (r_out_valid & out_ready & (r_issue_cnt != {CNT_W{1'b1}})) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_take) begin
                r_out_valid <= 1'b1;
                r_da <= w_da; r_aa <= w_aa; r_ba <= w_ba; r_sh <= w_sh;
                r_fs <= w_fs; r_bs <= w_bs; r_md <= w_md;
                r_ps <= w_ps; r_mw <= w_mw; r_rw <= w_rw; r_ma <= w_ma;
                r_mb <= w_mb; r_cs <= w_cs; r_oe <= w_oe; r_ill <= w_ill;
                if (w_ill) begin
                    r_ill_seen <= 1'b1;
                end
            end else if (w_load_en) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign DA = r_da;  assign AA = r_aa;  assign BA = r_ba;  assign SH = r_sh;
    assign FS = r_fs;  assign BS = r_bs;  assign MD = r_md;
    assign PS = r_ps;  assign MW = r_mw;  assign RW = r_rw;  assign MA = r_ma;
    assign MB = r_mb;  assign CS = r_cs;  assign OE = r_oe;
    assign ill_op    = r_ill;
    assign ill_seen  = r_ill_seen;
    assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: directed scenarios plus randomized traffic against a
// cycle-level reference model built from the instruction table. Counters run at 4 bits to reach saturation.
module tb_inst_decode_stage;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [2:0] da, aa, ba, sh;
        logic [3:0] fs;
        logic [1:0] bs, md;
        logic ps, mw, rw, ma, mb, cs, oe, ill;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [16:0] inst_in = 17'd0;
    logic in_ready, out_valid;
    logic [2:0] DA, AA, BA, SH;
    logic [3:0] FS;
    logic [1:0] BS, MD;
    logic PS, MW, RW, MA, MB, CS, OE, ill_op, ill_seen;
    logic [CNT_W-1:0] stall_cnt, issue_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    inst_decode_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst_in(inst_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .DA(DA), .AA(AA), .BA(BA), .SH(SH), .FS(FS), .BS(BS), .MD(MD),
        .PS(PS), .MW(MW), .RW(RW), .MA(MA), .MB(MB), .CS(CS), .OE(OE),
        .ill_op(ill_op), .ill_seen(ill_seen), .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    ctl_t dut_ctl;
    logic [37:0] dut_vec;
    assign dut_ctl = {DA, AA, BA, SH, FS, BS, MD, PS, MW, RW, MA, MB, CS, OE, ill_op};
    assign dut_vec = {out_valid, dut_ctl, ill_seen, issue_cnt, stall_cnt};

    // ---------------- reference model ----------------
    ctl_t       m_ctl;
    logic       m_ov, m_pend, m_ill_seen;
    logic [2:0] m_ld_da;
    int         m_issue, m_stall;

    function automatic logic [16:0] mk(input logic [4:0] op, input logic [2:0] da, aa, ba, sh);
        return {op, da, aa, ba, sh};
    endfunction

    function automatic ctl_t decode(input logic [16:0] w);
        logic [4:0] op;
        ctl_t c;
        op = w[16:12];
        c = '0;
        c.da = w[11:9];
        c.aa = w[8:6];
        case (op)
            5'd0:  begin c.da = 3'd0; c.aa = 3'd0; end
            5'd1, 5'd3, 5'd4, 5'd6, 5'd7, 5'd9: begin
                c.rw = 1'b1; c.fs = op[3:0]; c.ba = w[5:3];
                if (op == 5'd3) c.md = 2'd2;
                if (op == 5'd9) c.mb = 1'b1;
                if (op == 5'd7) c.sh = w[2:0];
            end
            5'd2:  begin c.fs = 4'd2; c.oe = 1'b1; c.ba = w[5:3]; end
            5'd5:  begin c.rw = 1'b1; c.fs = 4'd5; c.md = 2'd1; end
            5'd8:  begin c.rw = 1'b1; c.fs = 4'd8; end
            5'd10: begin c.rw = 1'b1; c.fs = 4'd10; c.mb = 1'b1; end
            5'd11: begin c.fs = 4'd11; c.bs = 2'b01; c.mb = 1'b1; c.cs = 1'b1; c.da = 3'd0; end
            5'd12: begin c.fs = 4'd12; c.bs = 2'b01; c.ps = 1'b1; c.mb = 1'b1; c.cs = 1'b1; c.da = 3'd0; end
            5'd13: begin c.mw = 1'b1; c.ba = w[5:3]; end
            5'd14: begin c.rw = 1'b1; c.fs = 4'd13; end
            5'd15: begin c.bs = 2'b11; c.mb = 1'b1; c.cs = 1'b1; c.da = 3'd0; c.aa = 3'd0; end
            5'd16: begin c.bs = 2'b10; c.rw = 1'b1; c.mb = 1'b1; c.cs = 1'b1; end
            default: begin c = '0; c.ill = 1'b1; end
        endcase
        return c;
    endfunction

    function automatic bit uses_a(input logic [4:0] op);
        return (op <= 5'd16) && (op != 5'd0) && (op != 5'd8) && (op != 5'd15);
    endfunction

    function automatic bit uses_b(input logic [4:0] op);
        return op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd9, 5'd13};
    endfunction

    function bit m_hazard();
`ifdef DEC_HAZARD_EN
        return m_pend && in_valid &&
               ((uses_a(inst_in[16:12]) && inst_in[8:6] == m_ld_da) ||
                (uses_b(inst_in[16:12]) && inst_in[5:3] == m_ld_da));
`else
        return 1'b0;
`endif
    endfunction

    function bit m_in_ready();
        return (!m_ov || out_ready) && !m_hazard() && !flush;
    endfunction

    function logic [37:0] exp_vec();
        return {m_ov, m_ctl, m_ill_seen, CNT_W'(m_issue), CNT_W'(m_stall)};
    endfunction

    // Reference model: one transaction-level update per clock
    always @(posedge clk or posedge rst) begin : model
        bit le, hz;
        if (rst) begin
            m_ctl = '0; m_ov = 1'b0; m_pend = 1'b0; m_ill_seen = 1'b0;
            m_ld_da = 3'd0; m_issue = 0; m_stall = 0;
        end else begin
            le = !m_ov || out_ready;
            hz = m_hazard();
            if (m_ov && out_ready && m_issue < 15) m_issue++;
            if (flush) begin
                m_ov = 1'b0; m_pend = 1'b0;
            end else if (le) begin
                if (in_valid && !hz) begin
                    m_ctl = decode(inst_in);
                    m_ov = 1'b1;
                    m_pend = (inst_in[16:12] == 5'd5);
                    m_ld_da = inst_in[11:9];
                    if (m_ctl.ill) m_ill_seen = 1'b1;
                end else if (hz) begin
                    m_ov = 1'b0; m_pend = 1'b0;
                    if (m_stall < 15) m_stall++;
                end else begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [16:0] w, input logic ordy, input logic fl);
        in_valid = v; inst_in = w; out_ready = ordy; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 17'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec !== 38'd0) begin
            n_bad++; $display("FAIL reset_state: got %h expected %h", dut_vec, 38'd0);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        drive(1'b1, 17'h0_12C8, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL add_in_ready: got %b expected 1", in_ready);
        end
        tick();
        n_cmp++;
        if ({out_valid, RW, FS, BA, DA, AA} !== {1'b1, 1'b1, 4'd1, 3'd1, 3'd1, 3'd3}) begin
            n_bad++; $display("FAIL add_decode: got ov=%b rw=%b fs=%0d ba=%0d da=%0d aa=%0d", out_valid, RW, FS, BA, DA, AA);
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL add_model: got %h expected %h", dut_vec, exp_vec());
        end
        drive(1'b0, 17'd0, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if ({out_valid, issue_cnt} !== {1'b0, 4'd1}) begin
            n_bad++; $display("FAIL add_drain: got ov=%b issue=%0d expected ov=0 issue=1", out_valid, issue_cnt);
        end
    endtask

    task automatic test_load_use();
        logic [3:0] st0;
        st0 = stall_cnt;
        drive(1'b1, mk(5'd5, 3'd2, 3'd1, 3'd0, 3'd0), 1'b1, 1'b0);
        tick();
        drive(1'b1, mk(5'd1, 3'd6, 3'd2, 3'd5, 3'd0), 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== m_in_ready()) begin
            n_bad++; $display("FAIL loaduse_in_ready: got %b expected %b", in_ready, m_in_ready());
        end
        tick();
`ifdef DEC_HAZARD_EN
        n_cmp++;
        if ({out_valid, stall_cnt} !== {1'b0, st0 + 4'd1}) begin
            n_bad++; $display("FAIL loaduse_bubble: got ov=%b stall=%0d expected ov=0 stall=%0d", out_valid, stall_cnt, st0 + 4'd1);
        end
        tick();
`endif
        n_cmp++;
        if ({out_valid, FS, AA} !== {1'b1, 4'd1, 3'd2}) begin
            n_bad++; $display("FAIL loaduse_dependent: got ov=%b fs=%0d aa=%0d expected ov=1 fs=1 aa=2", out_valid, FS, AA);
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL loaduse_model: got %h expected %h", dut_vec, exp_vec());
        end
        drive(1'b0, 17'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_no_dep();
        logic [3:0] st0;
        st0 = stall_cnt;
        drive(1'b1, mk(5'd5, 3'd2, 3'd1, 3'd0, 3'd0), 1'b1, 1'b0);
        tick();
        drive(1'b1, mk(5'd1, 3'd5, 3'd3, 3'd4, 3'd0), 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL nodep_in_ready: got %b expected 1", in_ready);
        end
        tick();
        n_cmp++;
        if ({out_valid, stall_cnt, AA, BA} !== {1'b1, st0, 3'd3, 3'd4}) begin
            n_bad++; $display("FAIL nodep_load: got ov=%b stall=%0d aa=%0d ba=%0d", out_valid, stall_cnt, AA, BA);
        end
        drive(1'b0, 17'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_backpressure();
        ctl_t held;
        logic [16:0] nxt;
        nxt = mk(5'd13, 3'd4, 3'd5, 3'd6, 3'd1);
        drive(1'b1, mk(5'd10, 3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 1'b0);
        tick();
        held = dut_ctl;
        drive(1'b1, nxt, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready);
            end
            tick();
            n_cmp++;
            if ({out_valid, dut_ctl} !== {1'b1, decode(mk(5'd10, 3'd1, 3'd2, 3'd3, 3'd4))} || dut_ctl !== held) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got ov=%b ctl=%h", i, out_valid, dut_ctl);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        tick();
        n_cmp++;
        if ({out_valid, dut_ctl} !== {1'b1, decode(nxt)}) begin
            n_bad++; $display("FAIL bp_release_load: got ov=%b ctl=%h expected ctl=%h", out_valid, dut_ctl, decode(nxt));
        end
        drive(1'b0, 17'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_illegal();
        drive(1'b1, {5'd20, 12'hABC}, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if ({out_valid, ill_op, RW, MW, ill_seen} !== 5'b11001) begin
            n_bad++; $display("FAIL illegal_decode: got ov=%b ill=%b rw=%b mw=%b seen=%b", out_valid, ill_op, RW, MW, ill_seen);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 17'd0, 1'b1, 1'b0);
            tick();
            n_cmp++;
            if ({ill_op, ill_seen} !== 2'b01) begin
                n_bad++; $display("FAIL illegal_sticky[%0d]: got ill=%b seen=%b expected ill=0 seen=1", i, ill_op, ill_seen);
            end
        end
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 38'd0) begin
            n_bad++; $display("FAIL illegal_reset: got %h expected 0", dut_vec);
        end
        drive(1'b0, 17'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_flush();
        logic [3:0] st0;
        st0 = stall_cnt;
        drive(1'b1, mk(5'd5, 3'd2, 3'd0, 3'd0, 3'd0), 1'b1, 1'b0);
        tick();
        drive(1'b1, mk(5'd1, 3'd1, 3'd2, 3'd2, 3'd0), 1'b1, 1'b1);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL flush_in_ready: got %b expected 0", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_squash: got ov=%b expected 0", out_valid);
        end
        flush = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_no_hazard: got in_ready=%b expected 1", in_ready);
        end
        tick();
        n_cmp++;
        if ({out_valid, FS, stall_cnt} !== {1'b1, 4'd1, st0}) begin
            n_bad++; $display("FAIL flush_dependent: got ov=%b fs=%0d stall=%0d", out_valid, FS, stall_cnt);
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL flush_model: got %h expected %h", dut_vec, exp_vec());
        end
        drive(1'b0, 17'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int i = 0; i < 600; i++) begin
            op = 5'($urandom_range(0, 22));
            drive(1'($urandom_range(0, 3) != 0),
                  mk(op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
            #1;
            n_cmp++;
            if (in_ready !== m_in_ready()) begin
                n_bad++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, in_ready, m_in_ready());
            end
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL rand_state[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (issue_cnt !== 4'hF) begin
            n_bad++; $display("FAIL issue_saturate: got %0d expected 15", issue_cnt);
        end
        drive(1'b0, 17'd0, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_no_dep();
        test_backpressure();
        test_illegal();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
